// File: rtl/sd_write_bridge.sv
// Bus-mapped SD sector writer: the CPU fills a 512-byte buffer and sets a sector number,
// then a START store streams the sector to the SD controller over its wr/din handshake.
module sd_write_bridge #(
  parameter logic [63:0] BUF_BASE   = 64'h0000_0000_0000_4000,
  parameter logic [63:0] ADDR_REG   = 64'h0000_0000_0000_4200,
  parameter logic [63:0] START_REG  = 64'h0000_0000_0000_4208,
  parameter logic [63:0] STATUS_REG = 64'h0000_0000_0000_4210,
  parameter logic [23:0] TIMEOUT    = 24'd5_000_000
) (
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic        bus_read_done,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  output logic [31:0] sd_wr_addr,
  output logic        sd_wr_busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_REQ      = 3'd2,
    S_STREAM   = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_buf [0:511];
  logic [8:0]  r_byte_idx;
  logic [23:0] r_timer;
  logic        r_done;
  logic        r_err;
  logic        r_rej;
  logic [31:0] r_wr_addr;
  logic [7:0]  r_din;
  logic        r_start_p0;
  logic        r_rfnb_p0;
  logic        r_rd_hold;
  logic        r_rd_done;
  logic [63:0] r_rd_data;

  logic [63:0] w_buf_off;
  logic        w_hit_buf;
  logic        w_hit_addr;
  logic        w_hit_start;
  logic        w_hit_status;
  logic        w_start_lvl;
  logic        w_start;
  logic        w_wr_buf;
  logic        w_wr_addr;
  logic        w_fall;
  logic        w_timeout;
  logic        w_byte_step;
  logic        w_rd_first;
  logic        w_unused;

  assign w_buf_off    = bus_address - BUF_BASE;
  assign w_hit_buf    = (bus_address >= BUF_BASE) && (w_buf_off < 64'd512);
  assign w_hit_addr   = (bus_address == ADDR_REG);
  assign w_hit_start  = (bus_address == START_REG);
  assign w_hit_status = (bus_address == STATUS_REG);

  // A held START strobe must launch only one transfer, so only its rising edge counts.
  assign w_start_lvl = bus_write_enable && w_hit_start;
  assign w_start     = w_start_lvl && !r_start_p0;
  assign w_wr_buf    = bus_write_enable && w_hit_buf && !sd_wr_busy;
  assign w_wr_addr   = bus_write_enable && w_hit_addr && !sd_wr_busy;

  assign w_fall      = r_rfnb_p0 && !sd_ready_for_next_byte;
  assign w_timeout   = (r_state != S_IDLE) && (r_timer == TIMEOUT);
  assign w_byte_step = (r_state == S_STREAM) && w_fall && !w_timeout;
  assign w_rd_first  = bus_read_enable && (w_hit_status || w_hit_buf) && !r_rd_hold;
  assign w_unused    = ^bus_write_data[63:32];

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_start) w_state_nxt = S_WAIT_RDY;
        S_WAIT_RDY: if (sd_ready) w_state_nxt = S_REQ;
        S_REQ:      if (!sd_ready) w_state_nxt = S_STREAM;
        S_STREAM:   if (w_fall && (r_byte_idx == 9'd511)) w_state_nxt = S_DRAIN;
        S_DRAIN:    if (sd_ready) w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sd_wr      = 1'b0;
    sd_wr_busy = 1'b1;
    case (r_state)
      S_IDLE:  sd_wr_busy = 1'b0;
      S_REQ:   sd_wr      = 1'b1;
      default: sd_wr      = 1'b0;
    endcase
  end

  // Control, flags and the 9-bit byte index; the index wrapping to 0 marks the end of a sector.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_byte_idx <= '0;
      r_timer    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rej      <= 1'b0;
      r_wr_addr  <= '0;
      r_start_p0 <= 1'b0;
      r_rfnb_p0  <= 1'b0;
    end else begin
      r_start_p0 <= w_start_lvl;
      r_rfnb_p0  <= sd_ready_for_next_byte;
      if (w_wr_addr) r_wr_addr <= bus_write_data[31:0];

      if ((w_state_nxt != r_state) || w_byte_step) r_timer <= '0;
      else if (r_state != S_IDLE)                  r_timer <= r_timer + 24'd1;

      if (w_start && (r_state == S_IDLE)) begin
        r_byte_idx <= '0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end else if (w_byte_step) begin
        r_byte_idx <= r_byte_idx + 9'd1;
      end

      if (w_start && (r_state != S_IDLE)) r_rej <= 1'b1;

      if (w_timeout) begin
        r_err  <= 1'b1;
        r_done <= 1'b0;
      end else if ((r_state == S_DRAIN) && sd_ready) begin
        r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_wr_buf) r_buf[w_buf_off[8:0]] <= bus_write_data[7:0];
  end

  // Registered RAM reads: streaming byte, then the one-shot bus load response.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_din     <= '0;
      r_rd_hold <= 1'b0;
      r_rd_done <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_din     <= r_buf[r_byte_idx];
      r_rd_hold <= bus_read_enable;
      r_rd_done <= w_rd_first;
      if (w_rd_first) begin
        if (w_hit_status) r_rd_data <= {60'd0, r_rej, r_err, r_done, sd_wr_busy};
        else              r_rd_data <= {56'd0, r_buf[w_buf_off[8:0]]};
      end
    end
  end

  assign bus_read_data = r_rd_data;
  assign bus_read_done = r_rd_done;
  assign sd_din        = r_din;
  assign sd_wr_addr    = r_wr_addr;

endmodule

// File: tb/tb_sd_write_bridge.sv
// Directed bench for sd_write_bridge: the bench plays both the CPU and the SD controller.
module tb_sd_write_bridge;

  localparam logic [63:0] BUF_BASE   = 64'h0000_0000_0000_4000;
  localparam logic [63:0] ADDR_REG   = 64'h0000_0000_0000_4200;
  localparam logic [63:0] START_REG  = 64'h0000_0000_0000_4208;
  localparam logic [63:0] STATUS_REG = 64'h0000_0000_0000_4210;

  logic        CLOCK_50 = 1'b0;
  logic        KEY0;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic        bus_read_done;
  logic        sd_ready;
  logic        sd_ready_for_next_byte;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic [31:0] sd_wr_addr;
  logic        sd_wr_busy;

  int vectors     = 0;
  int miscompares = 0;
  int wr_rises    = 0;
  int byte_bad    = 0;
  int byte_pos    = 0;
  logic [7:0] exp_buf [0:511];

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge sd_wr) wr_rises++;

  sd_write_bridge #(.TIMEOUT(24'd100)) dut (
    .CLOCK_50               (CLOCK_50),
    .KEY0                   (KEY0),
    .bus_address            (bus_address),
    .bus_write_data         (bus_write_data),
    .bus_write_enable       (bus_write_enable),
    .bus_read_enable        (bus_read_enable),
    .bus_read_data          (bus_read_data),
    .bus_read_done          (bus_read_done),
    .sd_ready               (sd_ready),
    .sd_ready_for_next_byte (sd_ready_for_next_byte),
    .sd_wr                  (sd_wr),
    .sd_din                 (sd_din),
    .sd_wr_addr             (sd_wr_addr),
    .sd_wr_busy             (sd_wr_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic bus_wr(input logic [63:0] a, input logic [63:0] d);
    bus_address      = a;
    bus_write_data   = d;
    bus_write_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0;
  endtask

  task automatic bus_rd(input logic [63:0] a, input int hold,
                        output logic [63:0] d, output int first, output int pulses);
    d      = 64'hDEAD_DEAD_DEAD_DEAD;
    first  = -1;
    pulses = 0;
    bus_address     = a;
    bus_read_enable = 1'b1;
    for (int c = 1; c <= hold; c++) begin
      tick();
      if (bus_read_done) begin
        pulses++;
        if (first < 0) begin
          first = c;
          d     = bus_read_data;
        end
      end
    end
    bus_read_enable = 1'b0;
    tick();
    if (bus_read_done) pulses++;
  endtask

  task automatic accept();
    int n;
    n = 0;
    while (!sd_wr && n < 20) begin
      tick();
      n++;
    end
    chk("sd_wr_asserted", {63'd0, sd_wr}, 64'd1);
    sd_ready = 1'b0;
    tick();
    chk("sd_wr_dropped", {63'd0, sd_wr}, 64'd0);
  endtask

  task automatic send_bytes(input int n);
    for (int k = 0; k < n; k++) begin
      sd_ready_for_next_byte = 1'b1;
      tick();
      if (sd_din !== exp_buf[byte_pos % 512]) byte_bad++;
      byte_pos++;
      sd_ready_for_next_byte = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic drain();
    chk("busy_in_drain", {63'd0, sd_wr_busy}, 64'd1);
    sd_ready = 1'b1;
    tick();
    chk("idle_after_drain", {63'd0, sd_wr_busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    int first;
    int pulses;
    int cnt;
    int rises_before;

    KEY0                   = 1'b0;
    bus_address            = '0;
    bus_write_data         = '0;
    bus_write_enable       = 1'b0;
    bus_read_enable        = 1'b0;
    sd_ready               = 1'b1;
    sd_ready_for_next_byte = 1'b0;

    #15;
    chk("reset_sd_wr",     {63'd0, sd_wr}, 64'd0);
    chk("reset_busy",      {63'd0, sd_wr_busy}, 64'd0);
    chk("reset_wr_addr",   {32'd0, sd_wr_addr}, 64'd0);
    chk("reset_din",       {56'd0, sd_din}, 64'd0);
    chk("reset_read_data", bus_read_data, 64'd0);
    chk("reset_read_done", {63'd0, bus_read_done}, 64'd0);
    KEY0 = 1'b1;
    tick();

    // Fill the sector buffer with its own index, with junk in the unused data bits.
    for (int i = 0; i < 512; i++) begin
      exp_buf[i] = 8'(i);
      bus_wr(BUF_BASE + 64'(i), {32'hDEAD_BEEF, 24'hABCDEF, exp_buf[i]});
    end
    bus_wr(ADDR_REG, 64'hCAFE_0000_0000_0010);
    chk("wr_addr_set", {32'd0, sd_wr_addr}, 64'h10);
    bus_rd(STATUS_REG, 1, rd, first, pulses);
    chk("status_initial", rd, 64'd0);
    bus_rd(BUF_BASE + 64'd5, 1, rd, first, pulses);
    chk("buf5_readback", rd, 64'h05);
    bus_rd(64'h0000_0000_0000_5000, 3, rd, first, pulses);
    chk("unmatched_no_done", 64'(pulses), 64'd0);

    // Transfer 1: status read and rejected buffer store while streaming.
    byte_pos = 0;
    byte_bad = 0;
    bus_wr(START_REG, 64'd0);
    chk("busy_after_start", {63'd0, sd_wr_busy}, 64'd1);
    accept();
    send_bytes(10);
    bus_rd(STATUS_REG, 1, rd, first, pulses);
    chk("status_streaming", rd, 64'h1);
    chk("status_done_latency", 64'(first), 64'd1);
    bus_wr(BUF_BASE + 64'd3, 64'hAA);
    send_bytes(502);
    drain();
    chk("xfer1_bytes_bad", 64'(byte_bad), 64'd0);
    chk("xfer1_wr_rises", 64'(wr_rises), 64'd1);
    chk("xfer1_wr_addr", {32'd0, sd_wr_addr}, 64'h10);
    bus_rd(STATUS_REG, 1, rd, first, pulses);
    chk("status_done", rd, 64'h2);
    bus_rd(BUF_BASE + 64'd3, 1, rd, first, pulses);
    chk("buf3_protected", rd, 64'h03);

    // Transfer 2: second START mid-stream is rejected.
    byte_pos = 0;
    byte_bad = 0;
    bus_wr(START_REG, 64'd0);
    accept();
    send_bytes(100);
    bus_wr(START_REG, 64'd0);
    chk("busy_after_restart", {63'd0, sd_wr_busy}, 64'd1);
    send_bytes(412);
    drain();
    chk("xfer2_bytes_bad", 64'(byte_bad), 64'd0);
    chk("xfer2_wr_rises", 64'(wr_rises), 64'd2);
    bus_rd(STATUS_REG, 1, rd, first, pulses);
    chk("status_rej_done", rd, 64'hA);

    // Transfer 3: asynchronous reset at byte 200, then a fresh transfer.
    byte_pos = 0;
    byte_bad = 0;
    bus_wr(START_REG, 64'd0);
    accept();
    send_bytes(200);
    chk("xfer3_partial_bad", 64'(byte_bad), 64'd0);
    #4;
    KEY0 = 1'b0;
    #1;
    chk("rst_mid_sd_wr", {63'd0, sd_wr}, 64'd0);
    chk("rst_mid_busy",  {63'd0, sd_wr_busy}, 64'd0);
    chk("rst_mid_addr",  {32'd0, sd_wr_addr}, 64'd0);
    sd_ready               = 1'b1;
    sd_ready_for_next_byte = 1'b0;
    #4;
    KEY0 = 1'b1;
    tick();
    bus_rd(STATUS_REG, 1, rd, first, pulses);
    chk("status_after_reset", rd, 64'd0);
    byte_pos = 0;
    byte_bad = 0;
    bus_wr(START_REG, 64'd0);
    accept();
    send_bytes(512);
    drain();
    chk("xfer4_bytes_bad", 64'(byte_bad), 64'd0);
    bus_rd(STATUS_REG, 1, rd, first, pulses);
    chk("status_after_xfer4", rd, 64'h2);

    // Held load strobe answers once.
    bus_rd(STATUS_REG, 10, rd, first, pulses);
    chk("held_read_pulses", 64'(pulses), 64'd1);
    chk("held_read_first", 64'(first), 64'd1);
    chk("held_read_data", rd, 64'h2);

    // Controller never ready: timeout after 101 busy cycles.
    sd_ready     = 1'b0;
    rises_before = wr_rises;
    bus_wr(START_REG, 64'd0);
    cnt = 0;
    while (sd_wr_busy && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("timeout_busy_cycles", 64'(cnt), 64'd101);
    chk("timeout_no_sd_wr", 64'(wr_rises), 64'(rises_before));
    bus_rd(STATUS_REG, 1, rd, first, pulses);
    chk("status_timeout", rd, 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_write_bridge.md
Name: sd_write_bridge

Overview:
- Bus-mapped SD sector writer; the outbound counterpart of the SD sector-read cache path.
- The CPU fills a 512-byte sector buffer with byte stores, writes the target sector number, then triggers a write.
- The block then drives the SD controller's wr/din/ready_for_next_byte handshake to stream the sector to the card, and reports busy/done/error via a status register.

Parameters:
- BUF_BASE, 64'h0000_0000_0000_4000, base of the 512-byte sector buffer window
- ADDR_REG, 64'h0000_0000_0000_4200, sector address register (write-only)
- START_REG, 64'h0000_0000_0000_4208, any write starts a sector write
- STATUS_REG, 64'h0000_0000_0000_4210, status register (read-only)
- TIMEOUT, 24'd5_000_000, max cycles spent in any wait state before abort (100 ms at 50 MHz)

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- KEY0  in  1  reset, asynchronous, active-low
- bus_address  in  64  CPU bus address
- bus_write_data  in  64  CPU store data; only [31:0] or [7:0] used as stated below
- bus_write_enable  in  1  store strobe, level
- bus_read_enable  in  1  load strobe, level, held until bus_read_done
- bus_read_data  out  64  load data
- bus_read_done  out  1  one-cycle load-complete pulse
- sd_ready  in  1  controller idle/ready
- sd_ready_for_next_byte  in  1  controller requests the next byte
- sd_wr  out  1  write request to controller
- sd_din  out  8  byte to controller
- sd_wr_addr  out  32  sector address to controller
- sd_wr_busy  out  1  high when not IDLE; top level muxes the controller address and blocks reads while high

Behaviour:
- Reset values: all outputs 0, state IDLE, byte_idx 0, flags 0, sd_wr_addr 0, timer 0. Buffer RAM is not cleared.
- Buffer writes: bus_write_enable with addr in [BUF_BASE, BUF_BASE+512) stores bus_write_data[7:0] to buf[addr-BUF_BASE]. Writes are ignored while sd_wr_busy.
- ADDR_REG write: sd_wr_addr <= bus_write_data[31:0]. Ignored while busy.
- START_REG write: only the rising edge of (bus_write_enable & match) counts, so a held strobe gives one start.
  - In IDLE: clear done and err, byte_idx <= 0, timer <= 0, go to WAIT_RDY.
  - While busy: ignored, and the sticky rej flag is set.
- Reads: bus_read_enable plus a match on STATUS_REG or the buffer window gives data on bus_read_data and bus_read_done high, both exactly one cycle after the first enable cycle.
  - No further done pulse until bus_read_enable deasserts.
  - STATUS_REG returns {60'd0, rej, err, done, busy}.
  - Buffer read returns {56'd0, buf[i]}.
  - Unmatched addresses produce no response.
- FSM:
  - IDLE: wait for start.
  - WAIT_RDY: on sd_ready=1, assert sd_wr=1 and go to REQ.
  - REQ: hold sd_wr=1 until sd_ready=0 (controller accepted), then drop sd_wr and go to STREAM.
  - STREAM:
    - sd_din = buf[byte_idx] at all times; registered read, updated one cycle after byte_idx changes.
    - On a falling edge of sd_ready_for_next_byte (registered edge detect), byte_idx += 1.
    - When the 512th falling edge is seen (byte_idx wraps 511 to 0), go to DRAIN.
  - DRAIN: on sd_ready=1, set done=1 and go to IDLE.
- Timer: cleared on every state change and on every byte_idx increment; increments in WAIT_RDY, REQ, STREAM and DRAIN. On reaching TIMEOUT: sd_wr <= 0, err=1, done=0, go to IDLE. The buffer is untouched.
- byte_idx is 9 bits; the wrap is the end condition, not overflow.
- Simultaneous start and buffer write in the same cycle cannot occur (single bus). A start in the same cycle as ADDR_REG is impossible for the same reason.
- Reset asserted mid-transfer: immediate IDLE, sd_wr 0, flags cleared; the controller is reset by the same KEY0.
- sd_wr_busy = (state != IDLE), combinational from the state register.

Test Plan:
- Fill buf[i]=i[7:0] for i=0..511 and write ADDR_REG=32'h10, then START with a controller model giving 512 ready_for_next_byte pulses -> sd_wr_addr=0x10; one sd_wr assertion; bytes sampled during the high phases are 0x00..0xFF,0x00..0xFF in order; then STATUS=0b0010.
- Read STATUS during STREAM -> 0b0001, done pulse 1 cycle after enable; buffer store to BUF_BASE+3 while busy -> buf[3] unchanged, read back equals original.
- Second START mid-stream -> ignored, transfer completes normally, STATUS=0b1010.
- Controller model never raises sd_ready, TIMEOUT overridden to 100 -> sd_wr never asserted, busy drops after 101 cycles, STATUS=0b0100.
- KEY0 pulsed low at byte 200 -> sd_wr=0, busy=0, STATUS=0 immediately; new START afterwards streams from byte 0.
- bus_read_enable held 10 cycles on STATUS_REG -> exactly one bus_read_done pulse.
